tone_sequencer: RTL
===================

# tone_sequencer

Parametrised, programmable square-wave note sequencer for the audio jack. Holds `NUM_SEQS` writable sequences of up to `SEQ_LEN` notes, each note a (half-period, duration) pair. Plays a selected sequence once or looped on a start pulse, with stop, busy and done handshakes. Sits between game control logic and the audio output pin.

## Interface
- `CLK_FREQ`, 50_000_000: clk frequency in Hz; informational, used only to derive the `TICK_CYCLES` default.
- `TICK_CYCLES`, CLK_FREQ/1000: clk cycles per duration tick (1 ms default); ≥1.
- `SEQ_LEN`, 8: max notes per sequence; ≥2.
- `NUM_SEQS`, 4: number of sequences; ≥1.
- `HP_W`, 20: half-period field width.
- `DUR_W`, 10: duration field width.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  begin playback; sampled only in IDLE.
- `stop`  in  1  abort playback.
- `seq_sel`  in  clog2(NUM_SEQS) (min 1)  sequence to play; latched on accepted start.
- `loop`  in  1  repeat mode; latched on accepted start.
- `wr_en`  in  1  table write strobe.
- `wr_seq`  in  clog2(NUM_SEQS) (min 1)  write target sequence.
- `wr_idx`  in  clog2(SEQ_LEN)  write target note slot.
- `wr_hp`  in  HP_W  half-period in clk cycles; 0 = rest.
- `wr_dur`  in  DUR_W  duration in ticks; 0 = end-of-sequence marker.
- `audio_out`  out  1  square-wave output.
- `audio_en`  out  1  audio amplifier enable.
- `busy`  out  1  high while playing.
- `done`  out  1  one-cycle pulse on natural completion.
- `note_idx`  out  clog2(SEQ_LEN)  index of the note currently playing.

## Operation
- Table: NUM_SEQS×SEQ_LEN entries of {hp, dur}. Asynchronous read, synchronous write. Reset clears all entries to 0; an unwritten sequence is therefore empty.
- States: IDLE, PLAY.
- IDLE, `start`=1, `stop`=0: latch `seq_sel`/`loop`, idx=0, clear counters.
  - If entry 0 has dur=0: emit `done` and stay IDLE.
  - Otherwise go to PLAY.
- PLAY: the duration counter counts clk cycles; the note ends after dur×TICK_CYCLES cycles. At note end:
  - idx advances.
  - End of sequence is reached when idx was SEQ_LEN-1 or the next entry has dur=0.
  - At end of sequence: `loop`=1 wraps to idx 0; `loop`=0 returns to IDLE with `done`.
- Tone: hp≠0 toggles `audio_out` every hp cycles. Tone phase counter and `audio_out` reset to 0 at every note start, so each note starts low. hp=0 holds `audio_out` at 0.
- `stop`=1 in PLAY: IDLE next cycle, `audio_out`=0, no `done`. `stop` has priority over `start` and over note end in the same cycle.
- `start` while busy is ignored. `seq_sel`/`loop` changes during PLAY are ignored.
- Writes are legal at any time. A write to the playing sequence takes effect when that slot is next read: the current note is read live, so a hp/dur change on the current slot affects it immediately.
- `audio_en` = `busy`. `note_idx` holds its last value in IDLE.
- Counter widths: duration counter ≥ DUR_W + clog2(TICK_CYCLES) bits; no overflow is permitted.

## Timing
- Reset values: `audio_out`=0, `audio_en`=0, `busy`=0, `done`=0, `note_idx`=0, state IDLE, table zeroed. Reset mid-playback returns all of these next cycle.
- `start` sampled at edge t: `busy`/`audio_en` high from t+1. Note 0 occupies cycles t+1 .. t+dur0×TICK_CYCLES.
- First `audio_out` rise is hp cycles after note start; period is 2×hp.
- Back-to-back notes: zero gap; note k+1 begins the cycle after note k's last cycle.
- Natural end: `busy` falls and `done` pulses in the same cycle, the first cycle after the last note. A new `start` is accepted that cycle.
- Loop wrap: note 0 follows the last note with zero gap; `done` is never asserted in loop mode.

## Test plan
- TICK_CYCLES=10. Seq0 = {hp 3, dur 2}, {hp 0, dur 1}, {hp 5, dur 1}, then dur 0. Start → `busy` for 40 cycles.
  - `audio_out`: period 6 for 20 cycles, low 10, period 10 for 10.
  - `done` pulse on cycle 41; `note_idx` 0→1→2.
- Seq1 fully populated, 8 notes of dur 1, `loop`=1. Run 200 cycles → `note_idx` wraps 7→0 with no gap and no `done`. Assert `stop` → `busy`/`audio_out` 0 next cycle, no `done`.
- Start on empty seq2 → `done` pulse the next cycle, `busy` never high.
- `start` and `stop` same cycle in IDLE → stays IDLE. `start` during PLAY with a different `seq_sel` → ignored, playback unchanged.
- Assert `reset` mid-note → all outputs 0 next cycle. Replay seq0 → silent, table cleared.
- Rewrite the hp of slot 2 while slot 0 plays → slot 2 sounds with the new hp.

Source files
------------

// File: rtl/tone_sequencer.sv
// Programmable square-wave note sequencer: NUM_SEQS tables of {half-period, duration}
// notes, played once or looped on a start pulse.
module tone_sequencer #(
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned TICK_CYCLES = CLK_FREQ / 1000,
    parameter int unsigned SEQ_LEN     = 8,
    parameter int unsigned NUM_SEQS    = 4,
    parameter int unsigned HP_W        = 20,
    parameter int unsigned DUR_W       = 10,
    localparam int unsigned SEL_W      = (NUM_SEQS > 1) ? $clog2(NUM_SEQS) : 1,
    localparam int unsigned IDX_W      = $clog2(SEQ_LEN)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic [SEL_W-1:0] seq_sel,
    input  logic             loop,
    input  logic             wr_en,
    input  logic [SEL_W-1:0] wr_seq,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [HP_W-1:0]  wr_hp,
    input  logic [DUR_W-1:0] wr_dur,
    output logic             audio_out,
    output logic             audio_en,
    output logic             busy,
    output logic             done,
    output logic [IDX_W-1:0] note_idx
);

    localparam int unsigned TICK_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    // One spare bit so dur*TICK_CYCLES always fits.
    localparam int unsigned DC_W   = DUR_W + TICK_W + 1;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_PLAY = 1'b1;

    logic [HP_W-1:0]  hp_tab  [NUM_SEQS][SEQ_LEN];
    logic [DUR_W-1:0] dur_tab [NUM_SEQS][SEQ_LEN];

    logic [0:0]       state_q, state_d;
    logic [SEL_W-1:0] seq_q, seq_d;
    logic             loop_q, loop_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DC_W-1:0]  cnt_q, cnt_d;
    logic [HP_W-1:0]  ph_q, ph_d;
    logic             aud_q, aud_d;
    logic             done_q, done_d;

    logic [HP_W-1:0]  cur_hp;
    logic [DUR_W-1:0] cur_dur;
    logic [DC_W-1:0]  dur_cycles;
    logic [IDX_W-1:0] next_idx;
    logic             last_slot;
    logic             note_end;
    logic             seq_end;

    always_ff @(posedge clk) begin
        if (reset) begin
            hp_tab  <= '{default: '0};
            dur_tab <= '{default: '0};
        end else if (wr_en) begin
            hp_tab[wr_seq][wr_idx]  <= wr_hp;
            dur_tab[wr_seq][wr_idx] <= wr_dur;
        end
    end

    // Current note is read live so writes to the playing slot apply immediately.
    assign cur_hp     = hp_tab[seq_q][idx_q];
    assign cur_dur    = dur_tab[seq_q][idx_q];
    assign dur_cycles = DC_W'(cur_dur) * DC_W'(TICK_CYCLES);
    assign next_idx   = idx_q + IDX_W'(1);
    assign last_slot  = (idx_q == IDX_W'(SEQ_LEN - 1));
    assign note_end   = (cnt_q + DC_W'(1)) >= dur_cycles;
    assign seq_end    = last_slot || (dur_tab[seq_q][next_idx] == '0);

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        loop_d  = loop_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        ph_d    = ph_q;
        aud_d   = aud_q;
        done_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start && !stop) begin
                    seq_d  = seq_sel;
                    loop_d = loop;
                    idx_d  = '0;
                    cnt_d  = '0;
                    ph_d   = '0;
                    aud_d  = 1'b0;
                    if (dur_tab[seq_sel][IDX_W'(0)] == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = ST_PLAY;
                    end
                end
            end
            ST_PLAY: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                    ph_d    = '0;
                    aud_d   = 1'b0;
                end else if (note_end) begin
                    // Every note, including a loop wrap, starts low with a fresh phase.
                    cnt_d = '0;
                    ph_d  = '0;
                    aud_d = 1'b0;
                    if (!seq_end) begin
                        idx_d = next_idx;
                    end else if (loop_q) begin
                        idx_d = '0;
                    end else begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + DC_W'(1);
                    if (cur_hp == '0) begin
                        ph_d  = '0;
                        aud_d = 1'b0;
                    end else if ((ph_q + HP_W'(1)) >= cur_hp) begin
                        ph_d  = '0;
                        aud_d = !aud_q;
                    end else begin
                        ph_d = ph_q + HP_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            seq_q   <= '0;
            loop_q  <= 1'b0;
            idx_q   <= '0;
            cnt_q   <= '0;
            ph_q    <= '0;
            aud_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            loop_q  <= loop_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            ph_q    <= ph_d;
            aud_q   <= aud_d;
            done_q  <= done_d;
        end
    end

    assign busy      = (state_q == ST_PLAY);
    assign audio_en  = busy;
    assign audio_out = aud_q;
    assign done      = done_q;
    assign note_idx  = idx_q;

endmodule
